// File: rtl/gb_sound_pkg.sv
// -----------------------------------------------------------------------------
// gb_sound_pkg
//   Shared constants and types for the Game Boy sound channels.
//   - NOISE_DIV    : noise-channel divisor table, indexed by divisor code r
//   - LENGTH_MAX   : length counter load value for a length field of 0
//   - VOL_MAX      : envelope volume ceiling
//   - LFSR_SEED    : noise LFSR value after reset and on every trigger
//   - frame_edge_t : registered copies of the level inputs used for
//                    rising-edge detection on the base clock
// -----------------------------------------------------------------------------
package gb_sound_pkg;

    localparam logic [6:0] NOISE_DIV [8] = '{7'd8, 7'd16, 7'd32, 7'd48,
                                             7'd64, 7'd80, 7'd96, 7'd112};

    localparam logic [6:0]  LENGTH_MAX = 7'd64;
    localparam logic [3:0]  VOL_MAX    = 4'd15;
    localparam logic [14:0] LFSR_SEED  = 15'h7FFF;

    typedef struct packed {
        logic clk256;
        logic clk64;
        logic trigger;
    } frame_edge_t;

endpackage

// File: rtl/volume_envelope.sv
// -----------------------------------------------------------------------------
// volume_envelope
//   Volume envelope shared by the pulse and noise channels. A load restarts
//   the envelope at startVol; every `period` 64 Hz ticks the volume moves by
//   one step up or down, saturating at 15 or 0.
//
// Ports:
//   clk, rst_n : base clock, asynchronous active-low reset
//   startVol   : volume applied on load
//   envAdd     : 1 = step up, 0 = step down
//   period     : ticks per step; 0 freezes the volume
//   tick64     : one-clk pulse per 64 Hz frame-sequencer step
//   load       : one-clk restart pulse; takes priority over tick64
//   volume     : current envelope volume
// -----------------------------------------------------------------------------
module volume_envelope
    import gb_sound_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] startVol,
    input  logic       envAdd,
    input  logic [2:0] period,
    input  logic       tick64,
    input  logic       load,
    output logic [3:0] volume
);

    logic [3:0] volume_q,  volume_d;
    logic [2:0] env_cnt_q, env_cnt_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the if/else tree can infer a latch.
        volume_d  = volume_q;
        env_cnt_d = env_cnt_q;

        if (load) begin
            // A restart swallows a tick arriving in the same clk.
            volume_d  = startVol;
            env_cnt_d = period;
        end else if (tick64 && period != 3'd0) begin
            // Counting down from 1 (or from 0 after a mid-note period change)
            // is the step point.
            if (env_cnt_q > 3'd1) begin
                env_cnt_d = env_cnt_q - 3'd1;
            end else begin
                env_cnt_d = period;
                if (envAdd && volume_q != VOL_MAX) begin
                    volume_d = volume_q + 4'd1;
                end else if (!envAdd && volume_q != 4'd0) begin
                    volume_d = volume_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            volume_q  <= 4'd0;
            env_cnt_q <= 3'd0;
        end else begin
            volume_q  <= volume_d;
            env_cnt_q <= env_cnt_d;
        end
    end

    assign volume = volume_q;

endmodule

// File: rtl/noise_channel.sv
// -----------------------------------------------------------------------------
// noise_channel
//   Game Boy channel 4: pseudo-random noise from a 15/7-bit LFSR, gated by a
//   length counter and scaled by the volume envelope. Feeds the mixer's fourth
//   channel input.
//
// Ports:
//   clk, rst_n   : 4194304 Hz base clock, asynchronous active-low reset
//   clk256/clk64 : frame-sequencer timer levels (rising edges detected here)
//   lenLoad      : length field L, counter becomes 64-L on the next trigger
//   startVol, envAdd, period : envelope controls
//   clkShift, divCode        : LFSR clock period = NOISE_DIV[divCode] << clkShift
//   widthMode    : 1 = 7-bit LFSR
//   lenEnable    : length counter active
//   trigger      : rising edge restarts the channel
//   status       : channel-enabled flag (only with NOISE_STATUS_EN defined)
//   out          : registered 4-bit sample to the mixer
//
// Build option:
//   NOISE_STATUS_EN - adds the `status` output.
// -----------------------------------------------------------------------------
module noise_channel
    import gb_sound_pkg::*;
#(
    parameter int LFSR_W  = 15,
    parameter int TIMER_W = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk256,
    input  logic       clk64,
    input  logic [5:0] lenLoad,
    input  logic [3:0] startVol,
    input  logic       envAdd,
    input  logic [2:0] period,
    input  logic [3:0] clkShift,
    input  logic       widthMode,
    input  logic [2:0] divCode,
    input  logic       lenEnable,
    input  logic       trigger,
`ifdef NOISE_STATUS_EN
    output logic       status,
`endif
    output logic [3:0] out
);

    frame_edge_t        edge_q,        edge_d;
    logic               enabled_q,     enabled_d;
    logic [6:0]         len_cnt_q,     len_cnt_d;
    logic [5:0]         len_shadow_q,  len_shadow_d;
    logic               len_pending_q, len_pending_d;
    logic [TIMER_W-1:0] timer_q,       timer_d;
    logic [LFSR_W-1:0]  lfsr_q,        lfsr_d;
    logic [3:0]         out_q,         out_d;

    logic               tick256, tick64, tick_trig;
    logic               len_pending_now;
    logic               dac_on;
    logic               shift_ok;
    logic [TIMER_W-1:0] timer_reload;
    logic               lfsr_fb;
    logic [LFSR_W-1:0]  lfsr_shift;
    logic [3:0]         volume;

    assign tick256   = clk256  & ~edge_q.clk256;
    assign tick64    = clk64   & ~edge_q.clk64;
    assign tick_trig = trigger & ~edge_q.trigger;

    // There is no write strobe, so a change of lenLoad counts as a write.
    // It is remembered until the next trigger, which applies 64-L; a trigger
    // without a pending write only refills an exhausted counter to 64.
    assign len_pending_now = len_pending_q | (lenLoad != len_shadow_q);

    // Zero start volume with a decreasing envelope means the DAC is off and
    // a trigger cannot enable the channel.
    assign dac_on = (startVol != 4'd0) | envAdd;

    // Shifts of 14 and 15 never clock the LFSR; the timer parks at zero.
    assign shift_ok     = (clkShift[3:1] != 3'b111);
    assign timer_reload = shift_ok
                        ? (TIMER_W'(NOISE_DIV[divCode]) << clkShift) - TIMER_W'(1)
                        : '0;

    always_comb begin
        lfsr_fb    = lfsr_q[0] ^ lfsr_q[1];
        lfsr_shift = {lfsr_fb, lfsr_q[LFSR_W-1:1]};
        if (widthMode) begin
            lfsr_shift[6] = lfsr_fb;
        end
    end

    always_comb begin
        edge_d.clk256  = clk256;
        edge_d.clk64   = clk64;
        edge_d.trigger = trigger;
        enabled_d      = enabled_q;
        len_cnt_d      = len_cnt_q;
        len_shadow_d   = lenLoad;
        len_pending_d  = len_pending_now;
        timer_d        = timer_q;
        lfsr_d         = lfsr_q;
        out_d          = (enabled_q && !lfsr_q[0]) ? volume : 4'd0;

        if (tick_trig) begin
            // Trigger wins: a length tick in the same clk is dropped.
            enabled_d     = dac_on;
            len_pending_d = 1'b0;
            if (len_pending_now) begin
                len_cnt_d = LENGTH_MAX - {1'b0, lenLoad};
            end else if (len_cnt_q == 7'd0) begin
                len_cnt_d = LENGTH_MAX;
            end
            timer_d = timer_reload;
            lfsr_d  = LFSR_W'(LFSR_SEED);
        end else begin
            if (tick256 && lenEnable && len_cnt_q != 7'd0) begin
                len_cnt_d = len_cnt_q - 7'd1;
                if (len_cnt_q == 7'd1) begin
                    enabled_d = 1'b0;
                end
            end
            // The timer runs whether or not the channel is enabled; new
            // divider settings are picked up at the next reload.
            if (timer_q != '0) begin
                timer_d = timer_q - TIMER_W'(1);
            end else if (shift_ok) begin
                timer_d = timer_reload;
                lfsr_d  = lfsr_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q        <= '0;
            enabled_q     <= 1'b0;
            len_cnt_q     <= 7'd0;
            len_shadow_q  <= 6'd0;
            len_pending_q <= 1'b0;
            timer_q       <= '0;
            lfsr_q        <= LFSR_W'(LFSR_SEED);
            out_q         <= 4'd0;
        end else begin
            edge_q        <= edge_d;
            enabled_q     <= enabled_d;
            len_cnt_q     <= len_cnt_d;
            len_shadow_q  <= len_shadow_d;
            len_pending_q <= len_pending_d;
            timer_q       <= timer_d;
            lfsr_q        <= lfsr_d;
            out_q         <= out_d;
        end
    end

    volume_envelope u_envelope (
        .clk      (clk),
        .rst_n    (rst_n),
        .startVol (startVol),
        .envAdd   (envAdd),
        .period   (period),
        .tick64   (tick64),
        .load     (tick_trig),
        .volume   (volume)
    );

    assign out = out_q;

`ifdef NOISE_STATUS_EN
    assign status = enabled_q;
`endif

endmodule

// File: tb/tb_noise_channel.sv
// -----------------------------------------------------------------------------
// tb_noise_channel
//   Self-checking bench for noise_channel. A "parked" note is triggered with
//   r=0, s=0 so that the 15th LFSR shift leaves lfsr=15'h4000 (bit 0 low);
//   clkShift is then set to 14 so the LFSR stays there and out equals the
//   envelope volume whenever the channel is enabled.
// -----------------------------------------------------------------------------
module tb_noise_channel;

    logic       clk;
    logic       rst_n;
    logic       clk256;
    logic       clk64;
    logic [5:0] lenLoad;
    logic [3:0] startVol;
    logic       envAdd;
    logic [2:0] period;
    logic [3:0] clkShift;
    logic       widthMode;
    logic [2:0] divCode;
    logic       lenEnable;
    logic       trigger;
    logic [3:0] out;
`ifdef NOISE_STATUS_EN
    logic       status;
`endif

    noise_channel dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk256    (clk256),
        .clk64     (clk64),
        .lenLoad   (lenLoad),
        .startVol  (startVol),
        .envAdd    (envAdd),
        .period    (period),
        .clkShift  (clkShift),
        .widthMode (widthMode),
        .divCode   (divCode),
        .lenEnable (lenEnable),
        .trigger   (trigger),
`ifdef NOISE_STATUS_EN
        .status    (status),
`endif
        .out       (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef enum logic [1:0] {ACT_NONE, ACT_64, ACT_256, ACT_BOTH} act_e;

    typedef struct {
        string      name;
        bit         park;
        logic [3:0] sv;
        bit         add;
        logic [2:0] per;
        logic [5:0] len_load;
        bit         len_en;
        act_e       act;
        logic [3:0] exp_out;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit p256, input bit p64);
        clk256 = p256;
        clk64  = p64;
        tick(2);
        clk256 = 1'b0;
        clk64  = 1'b0;
        tick(2);
    endtask

    task automatic park_note();
        clkShift = 4'd0;
        divCode  = 3'd0;
        trigger  = 1'b1;
        tick(1);
        trigger  = 1'b0;
        tick(121);
        clkShift = 4'd14;
    endtask

    function automatic vec_t mk(input string name, input bit park,
                                input logic [3:0] sv, input bit add,
                                input logic [2:0] per, input logic [5:0] len_load,
                                input bit len_en, input act_e act,
                                input logic [3:0] exp_out);
        vec_t v;
        v.name     = name;
        v.park     = park;
        v.sv       = sv;
        v.add      = add;
        v.per      = per;
        v.len_load = len_load;
        v.len_en   = len_en;
        v.act      = act;
        v.exp_out  = exp_out;
        return v;
    endfunction

    function automatic logic [14:0] lfsr_step(input logic [14:0] s, input bit wm);
        logic        fb;
        logic [14:0] n;
        fb = s[0] ^ s[1];
        n  = {fb, s[14:1]};
        if (wm) n[6] = fb;
        return n;
    endfunction

    initial begin
        int          cnt;
        int          ones;
        logic [14:0] m;
        bit          got  [254];
        bit          expb [254];

        // ---------------- vector table ----------------
        vecs.push_back(mk("env_dec_start", 1, 15, 0, 1, 0, 0, ACT_NONE, 15));
        for (int i = 1; i <= 17; i++)
            vecs.push_back(mk("env_dec_tick", 0, 15, 0, 1, 0, 0, ACT_64,
                              (i > 15) ? 4'd0 : 4'(15 - i)));
        vecs.push_back(mk("env_inc_start", 1, 15, 1, 1, 0, 0, ACT_NONE, 15));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("env_sat15", 0, 15, 1, 1, 0, 0, ACT_64, 15));
        vecs.push_back(mk("env_p2_start", 1, 3, 1, 2, 0, 0, ACT_NONE, 3));
        vecs.push_back(mk("env_p2_t1", 0, 3, 1, 2, 0, 0, ACT_64, 3));
        vecs.push_back(mk("env_p2_t2", 0, 3, 1, 2, 0, 0, ACT_64, 4));
        vecs.push_back(mk("env_p2_t3", 0, 3, 1, 2, 0, 0, ACT_64, 4));
        vecs.push_back(mk("env_p2_t4", 0, 3, 1, 2, 0, 0, ACT_64, 5));
        vecs.push_back(mk("env_frozen_start", 1, 7, 0, 0, 0, 0, ACT_NONE, 7));
        vecs.push_back(mk("env_frozen_tick", 0, 7, 0, 0, 0, 0, ACT_64, 7));
        vecs.push_back(mk("len60_start", 1, 9, 0, 0, 60, 1, ACT_NONE, 9));
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk("len60_tick", 0, 9, 0, 0, 60, 1, ACT_256,
                              (i < 4) ? 4'd9 : 4'd0));
        vecs.push_back(mk("len_retrig_start", 1, 9, 0, 0, 60, 1, ACT_NONE, 9));
        for (int i = 1; i <= 64; i++)
            vecs.push_back(mk("len_retrig_tick", 0, 9, 0, 0, 60, 1, ACT_256,
                              (i < 64) ? 4'd9 : 4'd0));
        vecs.push_back(mk("len_off_start", 1, 9, 0, 0, 60, 0, ACT_NONE, 9));
        vecs.push_back(mk("len_off_tick", 0, 9, 0, 0, 60, 0, ACT_256, 9));
        vecs.push_back(mk("len_off_tick", 0, 9, 0, 0, 60, 0, ACT_256, 9));
        vecs.push_back(mk("both_start", 1, 8, 0, 1, 62, 1, ACT_NONE, 8));
        vecs.push_back(mk("both_tick1", 0, 8, 0, 1, 62, 1, ACT_BOTH, 7));
        vecs.push_back(mk("both_tick2", 0, 8, 0, 1, 62, 1, ACT_BOTH, 0));
        vecs.push_back(mk("dac_off_start", 1, 0, 0, 1, 62, 0, ACT_NONE, 0));
        vecs.push_back(mk("dac_off_env1", 0, 0, 1, 1, 62, 0, ACT_64, 0));
        vecs.push_back(mk("dac_off_env2", 0, 0, 1, 1, 62, 0, ACT_64, 0));
        vecs.push_back(mk("dac_on_start", 1, 0, 1, 1, 62, 0, ACT_NONE, 0));
        vecs.push_back(mk("dac_on_env1", 0, 0, 1, 1, 62, 0, ACT_64, 1));
        vecs.push_back(mk("dac_on_env2", 0, 0, 1, 1, 62, 0, ACT_64, 2));

        // ---------------- reset ----------------
        rst_n = 1'b0; clk256 = 1'b0; clk64 = 1'b0; lenLoad = 6'd0;
        startVol = 4'd0; envAdd = 1'b0; period = 3'd0; clkShift = 4'd0;
        widthMode = 1'b0; divCode = 3'd0; lenEnable = 1'b0; trigger = 1'b0;
        tick(3);
        check("reset_out", out, 0);
        check("reset_lfsr", dut.lfsr_q, 15'h7FFF);
        rst_n = 1'b1;

        // No trigger: the LFSR runs but the channel stays silent.
        startVol = 4'd9; envAdd = 1'b1;
        cnt = 0;
        repeat (10000) begin
            tick(1);
            if (out != 4'd0) cnt++;
        end
        check("idle_10k_nonzero", cnt, 0);

        // ---------------- first nonzero sample timing ----------------
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        cnt = 0;
        repeat (120) begin
            tick(1);
            if (out != 4'd0) cnt++;
        end
        check("first_14_shifts_silent", cnt, 0);
        tick(1);
        check("first_nonzero_clk122", out, 9);
        check("lfsr_after_15_shifts", dut.lfsr_q, 15'h4000);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            startVol  = vecs[i].sv;
            envAdd    = vecs[i].add;
            period    = vecs[i].per;
            lenLoad   = vecs[i].len_load;
            lenEnable = vecs[i].len_en;
            if (vecs[i].park) park_note();
            case (vecs[i].act)
                ACT_64:   pulse(1'b0, 1'b1);
                ACT_256:  pulse(1'b1, 1'b0);
                ACT_BOTH: pulse(1'b1, 1'b1);
                default:  ;
            endcase
            check(vecs[i].name, out, vecs[i].exp_out);
        end

        // ---------------- trigger beats same-clk frame ticks ----------------
        startVol = 4'd15; envAdd = 1'b0; period = 3'd1;
        lenLoad = 6'd63; lenEnable = 1'b1; clkShift = 4'd0; divCode = 3'd0;
        trigger = 1'b1; clk256 = 1'b1; clk64 = 1'b1;
        tick(1);
        trigger = 1'b0; clk256 = 1'b0; clk64 = 1'b0;
        tick(121);
        clkShift = 4'd14;
        check("trig_wins_env", out, 15);
        pulse(1'b1, 1'b0);
        check("trig_wins_len1", out, 0);

        // ---------------- s=14: LFSR never clocked ----------------
        startVol = 4'd5; envAdd = 1'b0; period = 3'd0; lenEnable = 1'b0;
        clkShift = 4'd14;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        cnt = 0;
        repeat (300) begin
            tick(1);
            if (out != 4'd0) cnt++;
        end
        check("s14_silent", cnt, 0);
        check("s14_lfsr_frozen", dut.lfsr_q, 15'h7FFF);

        // ---------------- 7-bit mode: output period of 127 shifts ----------------
        m = 15'h7FFF;
        for (int k = 0; k < 254; k++) begin
            expb[k] = ~m[0];
            m = lfsr_step(m, 1'b1);
        end
        widthMode = 1'b1; clkShift = 4'd0; divCode = 3'd0;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(1);
        got[0] = (out != 4'd0);
        for (int k = 1; k < 254; k++) begin
            tick(8);
            got[k] = (out != 4'd0);
        end
        cnt = 0;
        ones = 0;
        for (int k = 0; k < 254; k++) begin
            if (got[k] != expb[k]) cnt++;
            if (got[k]) ones++;
        end
        check("wm7_sequence", cnt, 0);
        cnt = 0;
        for (int k = 0; k < 127; k++)
            if (got[k] != got[k + 127]) cnt++;
        check("wm7_repeat_127", cnt, 0);
        // 127 is prime, so a non-constant sequence repeating at 127 has
        // exactly that period.
        check("wm7_not_constant", (ones > 0 && ones < 254), 1);

        // ---------------- asynchronous reset mid-note ----------------
        widthMode = 1'b0; startVol = 4'd6; envAdd = 1'b0; period = 3'd0;
        park_note();
        check("rst_pre_out", out, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out", out, 0);
        check("rst_async_lfsr", dut.lfsr_q, 15'h7FFF);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rst_post_out", out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
